// File: rtl/toa_encoder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// toa_encoder_pkg : shared constants for the TOA encoder           Rev 1.0
// ---------------------------------------------------------------------------
package toa_encoder_pkg;

  localparam int NTAP     = 63;
  localparam int RING_LEN = 126;
  localparam int COARSE_W = 3;
  localparam int FINE_W   = 7;
  localparam int POS_W    = 6;
  localparam int LEVEL_W  = 3;

  localparam logic [COARSE_W+FINE_W-1:0] ERR_CODE = '0;

  // Fold a 7-bit value into 0..RING_LEN-1 (inputs never exceed 2*RING_LEN-1).
  function automatic logic [FINE_W-1:0] mod_ring(input logic [FINE_W-1:0] v);
    return (v >= FINE_W'(RING_LEN)) ? v - FINE_W'(RING_LEN) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/toa_bubble_locator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// toa_bubble_locator : finds the single circular run of equal-neighbour taps
// Rev 1.0
// ---------------------------------------------------------------------------
module toa_bubble_locator
  import toa_encoder_pkg::*;
(
  input  logic [NTAP-1:0]    a_i,
  input  logic [LEVEL_W-1:0] level_i,
  output logic [POS_W-1:0]   start_o,
  output logic [POS_W-1:0]   len_o,
  output logic               valid_o
);

  logic [NTAP-1:0]  d;
  logic [NTAP-1:0]  run_head;
  logic [POS_W-1:0] n_heads;
  logic [LEVEL_W:0] max_len;

  for (genvar i = 0; i < NTAP; i++) begin : g_tap
    localparam int NXT = (i + 1) % NTAP;
    localparam int PRV = (i + NTAP - 1) % NTAP;
    assign d[i]        = ~(a_i[i] ^ a_i[NXT]);
    assign run_head[i] = d[i] & ~d[PRV];
  end

  // A run head is a set bit whose circular predecessor is clear, so a run
  // wrapping 62->0 yields exactly one head at its wrap-side start.
  always_comb begin
    n_heads = '0;
    start_o = '0;
    len_o   = '0;
    for (int i = 0; i < NTAP; i++) begin
      if (run_head[i]) begin
        n_heads = n_heads + POS_W'(1);
        start_o = POS_W'(i);
      end
      len_o = len_o + POS_W'(d[i]);
    end
    max_len = {level_i, 1'b1};
    valid_o = (n_heads == POS_W'(1)) &&
              (len_o <= POS_W'(max_len)) &&
              (len_o != POS_W'(NTAP));
  end

endmodule
`default_nettype wire

// File: rtl/toa_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// toa_encoder : ring-oscillator snapshot + coarse counters -> 10-bit TOA code
// Rev 1.0
// ---------------------------------------------------------------------------
module toa_encoder
  import toa_encoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NTAP-1:0]     A,
  input  logic [LEVEL_W-1:0]  level,
  input  logic [COARSE_W-1:0] counterA,
  input  logic [COARSE_W-1:0] counterB,
  input  logic [FINE_W-1:0]   offset,
  input  logic                selRawCode,
  output logic [COARSE_W-1:0] outputCoarsePhase,
  output logic [FINE_W-1:0]   outputFinePhase,
  output logic                errorFlag
);

  logic [POS_W-1:0]    run_start;
  logic [POS_W-1:0]    run_len;
  logic                run_valid;

  logic [FINE_W-1:0]   pos_sum;
  logic [POS_W-1:0]    pos;
  logic [FINE_W-1:0]   fine_raw;
  logic [FINE_W-1:0]   off_mod;
  logic [FINE_W:0]     fine_diff;
  logic [COARSE_W-1:0] coarse_sel;

  logic [COARSE_W-1:0] coarse_d, coarse_q;
  logic [FINE_W-1:0]   fine_d, fine_q;
  logic                err_d, err_q;

  toa_bubble_locator u_locator (
    .a_i     (A),
    .level_i (level),
    .start_o (run_start),
    .len_o   (run_len),
    .valid_o (run_valid)
  );

  always_comb begin
    pos_sum    = {1'b0, run_start} + {2'b00, run_len[POS_W-1:1]};
    pos        = (pos_sum >= FINE_W'(NTAP)) ? POS_W'(pos_sum - FINE_W'(NTAP))
                                            : pos_sum[POS_W-1:0];
    // The tap level at the transition tells which half of the ring we are in.
    fine_raw   = {1'b0, pos} + (A[pos] ? FINE_W'(NTAP) : FINE_W'(0));
    coarse_sel = (fine_raw < FINE_W'(NTAP)) ? counterB : counterA;
    off_mod    = mod_ring(offset);
    fine_diff  = {1'b0, fine_raw} - {1'b0, off_mod};

    coarse_d = ERR_CODE[FINE_W +: COARSE_W];
    fine_d   = ERR_CODE[FINE_W-1:0];
    err_d    = 1'b1;
    if (run_valid) begin
      err_d = 1'b0;
      if (selRawCode) begin
        coarse_d = counterA;
        fine_d   = fine_raw;
      end else if (fine_diff[FINE_W]) begin
        fine_d   = fine_diff[FINE_W-1:0] + FINE_W'(RING_LEN);
        coarse_d = coarse_sel - COARSE_W'(1);
      end else begin
        fine_d   = fine_diff[FINE_W-1:0];
        coarse_d = coarse_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coarse_q <= '0;
      fine_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      coarse_q <= coarse_d;
      fine_q   <= fine_d;
      err_q    <= err_d;
    end
  end

  assign outputCoarsePhase = coarse_q;
  assign outputFinePhase   = fine_q;
  assign errorFlag         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_toa_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_toa_encoder : scoreboard bench for toa_encoder                Rev 1.0
// ---------------------------------------------------------------------------
module tb_toa_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [62:0] A = '0;
  logic [2:0]  level = '0;
  logic [2:0]  counterA = '0;
  logic [2:0]  counterB = '0;
  logic [6:0]  offset = '0;
  logic        selRawCode = 1'b0;
  logic [2:0]  outputCoarsePhase;
  logic [6:0]  outputFinePhase;
  logic        errorFlag;

  typedef struct packed {
    logic       e;
    logic [2:0] c;
    logic [6:0] f;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  toa_encoder dut (
    .clk               (clk),
    .rst               (rst),
    .A                 (A),
    .level             (level),
    .counterA          (counterA),
    .counterB          (counterB),
    .offset            (offset),
    .selRawCode        (selRawCode),
    .outputCoarsePhase (outputCoarsePhase),
    .outputFinePhase   (outputFinePhase),
    .errorFlag         (errorFlag)
  );

  always #5 clk = ~clk;

  // Reference: list every maximal circular run by walking the ring from a
  // known break, then apply the arithmetic rules directly on integers.
  function automatic exp_t model(input logic [62:0] a, input int lvl, input int ca,
                                 input int cb, input int off, input int raw);
    exp_t e;
    int   d[63];
    int   ones, z, cur, cs, p, fr, co, f, idx;
    int   starts[$];
    int   lens[$];
    e    = '0;
    ones = 0;
    z    = -1;
    for (int i = 0; i < 63; i++) begin
      d[i] = (a[i] == a[(i + 1) % 63]) ? 1 : 0;
      ones += d[i];
      if (d[i] == 0 && z < 0) z = i;
    end
    if (ones == 0 || ones == 63) begin
      e.e = 1'b1;
      return e;
    end
    cur = 0;
    cs  = 0;
    for (int k = 1; k <= 63; k++) begin
      idx = (z + k) % 63;
      if (d[idx] == 1) begin
        if (cur == 0) cs = idx;
        cur++;
      end else if (cur > 0) begin
        starts.push_back(cs);
        lens.push_back(cur);
        cur = 0;
      end
    end
    if (starts.size() != 1 || lens[0] > 2 * lvl + 1) begin
      e.e = 1'b1;
      return e;
    end
    p  = (starts[0] + lens[0] / 2) % 63;
    fr = p + 63 * int'(a[p]);
    if (raw != 0) begin
      co = ca;
      f  = fr;
    end else begin
      co = (fr < 63) ? cb : ca;
      f  = fr - (off % 126);
      if (f < 0) begin
        f  = f + 126;
        co = (co + 7) % 8;
      end
    end
    e.c = co[2:0];
    e.f = f[6:0];
    return e;
  endfunction

  // Snapshot whose transition vector holds one run of L set bits from tap s.
  function automatic logic [62:0] build(input int s, input int L, input logic a0);
    logic [62:0] dv;
    logic [62:0] a;
    dv = '0;
    for (int k = 0; k < L; k++) dv[(s + k) % 63] = 1'b1;
    a[0] = a0;
    for (int i = 0; i < 62; i++) a[i + 1] = dv[i] ? a[i] : ~a[i];
    return a;
  endfunction

  task automatic apply_now(input logic [62:0] a, input logic [2:0] lv, input logic [2:0] ca,
                           input logic [2:0] cb, input logic [6:0] off, input logic raw);
    A          = a;
    level      = lv;
    counterA   = ca;
    counterB   = cb;
    offset     = off;
    selRawCode = raw;
    sb.push_back(model(a, int'(lv), int'(ca), int'(cb), int'(off), int'(raw)));
  endtask

  task automatic drive(input logic [62:0] a, input logic [2:0] lv, input logic [2:0] ca,
                       input logic [2:0] cb, input logic [6:0] off, input logic raw);
    @(negedge clk);
    apply_now(a, lv, ca, cb, off, raw);
  endtask

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t x;
    #1;
    if (!rst && sb.size() > 0) begin
      x = sb.pop_front();
      total++;
      if ({errorFlag, outputCoarsePhase, outputFinePhase} !== x) begin
        bad++;
        $display("FAIL toa_code got err=%0b coarse=%0d fine=%0d required err=%0b coarse=%0d fine=%0d",
                 errorFlag, outputCoarsePhase, outputFinePhase, x.e, x.c, x.f);
      end
    end
  end

  initial begin : stim
    logic [63:0] t64;
    logic [62:0] a_ex, a_alt, a_r;
    int          sel, s, L, bitpos;

    t64  = 64'h2AAF_5555_5555_5555;
    a_ex = t64[62:0];
    for (int i = 0; i < 63; i++) a_alt[i] = 1'(i % 2);

    #12;
    chk("reset_state", {errorFlag, outputCoarsePhase, outputFinePhase}, 11'd0);
    @(negedge clk);
    rst = 1'b0;

    drive(a_alt, 3'd0, 3'd1, 3'd5, 7'd0,   1'b0);  // coarse 5 fine 62
    drive(a_ex,  3'd3, 3'd2, 3'd4, 7'd0,   1'b0);  // coarse 2 fine 112
    drive(a_ex,  3'd3, 3'd2, 3'd4, 7'd120, 1'b0);  // coarse 1 fine 118
    drive(a_ex,  3'd3, 3'd0, 3'd4, 7'd120, 1'b0);  // coarse 7 fine 118
    drive(a_ex,  3'd0, 3'd2, 3'd4, 7'd0,   1'b0);  // error
    drive('0,    3'd7, 3'd2, 3'd4, 7'd0,   1'b0);  // error, L = 63
    drive('0,    3'd7, 3'd2, 3'd4, 7'd0,   1'b1);  // error in debug mode
    drive(a_ex,  3'd3, 3'd6, 3'd4, 7'd50,  1'b1);  // coarse 6 fine 112
    drive(a_ex,  3'd3, 3'd2, 3'd4, 7'd126, 1'b0);  // as offset 0
    drive(a_ex,  3'd3, 3'd2, 3'd4, 7'd127, 1'b0);  // as offset 1
    drive(build(62, 3, 1'b1), 3'd1, 3'd3, 3'd4, 7'd0, 1'b0);  // wrapping run
    drive(build(61, 5, 1'b0), 3'd2, 3'd3, 3'd4, 7'd5, 1'b0);
    drive(build(0, 15, 1'b1), 3'd7, 3'd3, 3'd0, 7'd0, 1'b0);
    drive(build(0, 17, 1'b1), 3'd7, 3'd3, 3'd0, 7'd0, 1'b0);  // too long

    // Mid-stream reset: the in-flight sample must be dropped.
    drive(a_alt, 3'd0, 3'd1, 3'd5, 7'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    apply_now(a_ex, 3'd3, 3'd2, 3'd4, 7'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("reset_async", {errorFlag, outputCoarsePhase, outputFinePhase}, 11'd0);
    sb.delete();
    @(posedge clk);
    #1;
    chk("reset_hold", {errorFlag, outputCoarsePhase, outputFinePhase}, 11'd0);
    @(negedge clk);
    rst = 1'b0;
    apply_now(a_ex, 3'd3, 3'd2, 3'd4, 7'd0, 1'b0);
    #1;
    chk("reset_release", {errorFlag, outputCoarsePhase, outputFinePhase}, 11'd0);

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 7);
      s   = $urandom_range(0, 62);
      L   = 2 * $urandom_range(0, 8) + 1;
      a_r = build(s, L, 1'($urandom_range(0, 1)));
      if (sel == 0) begin
        a_r = 63'({$urandom(), $urandom()});
      end else if (sel == 1) begin
        bitpos = $urandom_range(0, 62);
        a_r[bitpos] = ~a_r[bitpos];
      end
      drive(a_r, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
            1'($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d pending required=0 pending", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
